alu_exec: RTL

//  Two-stage pipelined integer execute unit; the consumer of the reservation station's ALU dispatch port.

---
 rtl/alu_exec_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_exec.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants and op-class decode for the integer execute unit.
package alu_exec_pkg;

   localparam int unsigned ROB_POS_WID = 4;
   localparam int unsigned OP_WID      = 7;
   localparam int unsigned FUNCT3_WID  = 3;

   localparam logic [OP_WID-1:0] OP_R     = 7'b0110011;
   localparam logic [OP_WID-1:0] OP_I     = 7'b0010011;
   localparam logic [OP_WID-1:0] OP_LUI   = 7'b0110111;
   localparam logic [OP_WID-1:0] OP_AUIPC = 7'b0010111;
   localparam logic [OP_WID-1:0] OP_JAL   = 7'b1101111;
   localparam logic [OP_WID-1:0] OP_JALR  = 7'b1100111;
   localparam logic [OP_WID-1:0] OP_BR    = 7'b1100011;

   // ALU funct3 codes
   localparam logic [FUNCT3_WID-1:0] F3_ADD  = 3'b000;
   localparam logic [FUNCT3_WID-1:0] F3_SLL  = 3'b001;
   localparam logic [FUNCT3_WID-1:0] F3_SLT  = 3'b010;
   localparam logic [FUNCT3_WID-1:0] F3_SLTU = 3'b011;
   localparam logic [FUNCT3_WID-1:0] F3_XOR  = 3'b100;
   localparam logic [FUNCT3_WID-1:0] F3_SR   = 3'b101;
   localparam logic [FUNCT3_WID-1:0] F3_OR   = 3'b110;
   localparam logic [FUNCT3_WID-1:0] F3_AND  = 3'b111;

   // Branch funct3 codes
   localparam logic [FUNCT3_WID-1:0] F3_BEQ  = 3'b000;
   localparam logic [FUNCT3_WID-1:0] F3_BNE  = 3'b001;
   localparam logic [FUNCT3_WID-1:0] F3_BLT  = 3'b100;
   localparam logic [FUNCT3_WID-1:0] F3_BGE  = 3'b101;
   localparam logic [FUNCT3_WID-1:0] F3_BLTU = 3'b110;
   localparam logic [FUNCT3_WID-1:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      ClsNone,
      ClsOp,
      ClsOpImm,
      ClsLui,
      ClsAuipc,
      ClsJal,
      ClsJalr,
      ClsBranch
   } op_class_e;

   function automatic op_class_e decode_class(input logic [OP_WID-1:0] opcode);
      op_class_e cls;
      case (opcode)
         OP_R:     cls = ClsOp;
         OP_I:     cls = ClsOpImm;
         OP_LUI:   cls = ClsLui;
         OP_AUIPC: cls = ClsAuipc;
         OP_JAL:   cls = ClsJal;
         OP_JALR:  cls = ClsJalr;
         OP_BR:    cls = ClsBranch;
         default:  cls = ClsNone;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I ALU and branch comparator.
module alu_core
   import alu_exec_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   input  logic        funct7,
   input  logic        is_reg,   // register form: funct7 also selects SUB
   output logic [31:0] value,
   output logic        branch_cond
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   // Arithmetic/logic result
   always_comb begin
      value = '0;
      unique case (funct3)
         F3_ADD:  value = (funct7 && is_reg) ? (a - b) : (a + b);
         F3_SLL:  value = a << shamt;
         F3_SLT:  value = {31'b0, $signed(a) < $signed(b)};
         F3_SLTU: value = {31'b0, a < b};
         F3_XOR:  value = a ^ b;
         F3_SR:   value = funct7 ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
         F3_OR:   value = a | b;
         F3_AND:  value = a & b;
      endcase
   end

   // Branch condition; reserved funct3 values never take
   always_comb begin
      branch_cond = 1'b0;
      case (funct3)
         F3_BEQ:  branch_cond = (a == b);
         F3_BNE:  branch_cond = (a != b);
         F3_BLT:  branch_cond = $signed(a) < $signed(b);
         F3_BGE:  branch_cond = $signed(a) >= $signed(b);
         F3_BLTU: branch_cond = a < b;
         F3_BGEU: branch_cond = a >= b;
         default: branch_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Two-stage pipelined integer execute unit driving the ALU result bus.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int unsigned ROB_POS_W = ROB_POS_WID
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 alu_en,
   input  logic [31:0]          alu_val1,
   input  logic [31:0]          alu_val2,
   input  logic [31:0]          alu_imm,
   input  logic [31:0]          alu_pc,
   input  logic [6:0]           alu_opcode,
   input  logic [2:0]           alu_funct3,
   input  logic                 alu_funct7,
   input  logic [ROB_POS_W-1:0] alu_rob_pos,
   output logic                 result,
   output logic [31:0]          result_val,
   output logic [ROB_POS_W-1:0] result_rob_pos,
   output logic                 result_jump,
   output logic [31:0]          result_pc
);

   // Stage 1 state
   logic                 s1_valid_q, s1_valid_d;
   op_class_e            s1_cls_q, s1_cls_d;
   logic [31:0]          s1_a_q, s1_a_d;
   logic [31:0]          s1_b_q, s1_b_d;
   logic [31:0]          s1_pc_q, s1_pc_d;
   logic [31:0]          s1_imm_q, s1_imm_d;
   logic [2:0]           s1_f3_q, s1_f3_d;
   logic                 s1_f7_q, s1_f7_d;
   logic [ROB_POS_W-1:0] s1_rob_q, s1_rob_d;

   // Stage 2 (output) state
   logic                 result_q, result_d;
   logic [31:0]          val_q, val_d;
   logic [ROB_POS_W-1:0] rob_q, rob_d;
   logic                 jump_q, jump_d;
   logic [31:0]          pc_q, pc_d;

   logic [31:0] core_val;
   logic        core_br;
   logic [31:0] pc_plus4, pc_target, jalr_target;

   alu_core u_alu_core (
      .a           (s1_a_q),
      .b           (s1_b_q),
      .funct3      (s1_f3_q),
      .funct7      (s1_f7_q),
      .is_reg      (s1_cls_q == ClsOp),
      .value       (core_val),
      .branch_cond (core_br)
   );

   assign pc_plus4    = s1_pc_q + 32'd4;
   assign pc_target   = s1_pc_q + s1_imm_q;
   assign jalr_target = (s1_a_q + s1_imm_q) & ~32'd1;

   // Stage 1 capture; rollback kills the slot and blocks this cycle's dispatch
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_cls_d   = s1_cls_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_pc_d    = s1_pc_q;
      s1_imm_d   = s1_imm_q;
      s1_f3_d    = s1_f3_q;
      s1_f7_d    = s1_f7_q;
      s1_rob_d   = s1_rob_q;
      if (rdy) begin
         if (rollback) begin
            s1_valid_d = 1'b0;
         end else begin
            s1_valid_d = alu_en;
            if (alu_en) begin
               s1_cls_d = decode_class(alu_opcode);
               s1_a_d   = alu_val1;
               s1_b_d   = (decode_class(alu_opcode) == ClsOpImm) ? alu_imm : alu_val2;
               s1_pc_d  = alu_pc;
               s1_imm_d = alu_imm;
               s1_f3_d  = alu_funct3;
               s1_f7_d  = alu_funct7;
               s1_rob_d = alu_rob_pos;
            end
         end
      end
   end

   // Stage 2: resolve value, jump and next PC for the op leaving stage 1
   always_comb begin
      result_d = result_q;
      val_d    = val_q;
      rob_d    = rob_q;
      jump_d   = jump_q;
      pc_d     = pc_q;
      if (rdy) begin
         if (rollback) begin
            result_d = 1'b0;
         end else begin
            result_d = s1_valid_q;
            if (s1_valid_q) begin
               rob_d  = s1_rob_q;
               val_d  = '0;
               jump_d = 1'b0;
               pc_d   = pc_plus4;
               unique case (s1_cls_q)
                  ClsOp, ClsOpImm: val_d = core_val;
                  ClsLui:          val_d = s1_imm_q;
                  ClsAuipc:        val_d = pc_target;
                  ClsJal: begin
                     val_d  = pc_plus4;
                     jump_d = 1'b1;
                     pc_d   = pc_target;
                  end
                  ClsJalr: begin
                     val_d  = pc_plus4;
                     jump_d = 1'b1;
                     pc_d   = jalr_target;
                  end
                  ClsBranch: begin
                     jump_d = core_br;
                     pc_d   = core_br ? pc_target : pc_plus4;
                  end
                  ClsNone: val_d = '0;
               endcase
            end
         end
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_cls_q   <= ClsNone;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_pc_q    <= '0;
         s1_imm_q   <= '0;
         s1_f3_q    <= '0;
         s1_f7_q    <= 1'b0;
         s1_rob_q   <= '0;
         result_q   <= 1'b0;
         val_q      <= '0;
         rob_q      <= '0;
         jump_q     <= 1'b0;
         pc_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_cls_q   <= s1_cls_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_pc_q    <= s1_pc_d;
         s1_imm_q   <= s1_imm_d;
         s1_f3_q    <= s1_f3_d;
         s1_f7_q    <= s1_f7_d;
         s1_rob_q   <= s1_rob_d;
         result_q   <= result_d;
         val_q      <= val_d;
         rob_q      <= rob_d;
         jump_q     <= jump_d;
         pc_q       <= pc_d;
      end
   end

   assign result         = result_q;
   assign result_val     = val_q;
   assign result_rob_pos = rob_q;
   assign result_jump    = jump_q;
   assign result_pc      = pc_q;

endmodule
